his_acq_scheduler: RTL

//   Sequences the dToF histogram RAM: round-robin arbitrates N_REQ pixel TDC requesters onto one write port,

---
 rtl/his_acq_scheduler_if.sv | 30 +++
 rtl/his_acq_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/his_acq_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : his_acq_scheduler_if
// Brief    : Requester handshake and histogram RAM write/clear port bundle.
// Revision : 1.0
// ============================================================================
interface his_acq_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int NB    = 5,
    parameter int PIXW  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*NB-1:0] req_bin;
    logic [N_REQ-1:0]    req_ready;
    logic                wr_en;
    logic [PIXW+NB-1:0]  wr_addr;
    logic                wr_bank;
    logic                clr_en;

    modport master (
        output req_valid, req_bin,
        input  req_ready, wr_en, wr_addr, wr_bank, clr_en
    );

    modport slave (
        input  req_valid, req_bin,
        output req_ready, wr_en, wr_addr, wr_bank, clr_en
    );
endinterface
`default_nettype wire

// File: rtl/his_acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : his_acq_scheduler
// Brief    : dToF histogram RAM sequencer: clear, round-robin write, bank swap.
// Revision : 1.0
// ============================================================================
module his_acq_scheduler #(
    parameter int N_REQ   = 4,
    parameter int NB      = 5,
    parameter int ACQ_NUM = 16,
    parameter int PIXW    = $clog2(N_REQ)
) (
    input  wire logic          clk,
    input  wire logic          res,
    input  wire logic          start,
    input  wire logic          stop,
    input  wire logic          acq_tick,
    his_acq_scheduler_if.slave bus,
    output logic               frame_done,
    output logic               done_bank,
    output logic               busy,
    output logic               err_tick
);
    localparam int AW = PIXW + NB;
    localparam int CW = $clog2(ACQ_NUM + 1);
    localparam logic [AW-1:0] C_CLR_LAST = AW'(N_REQ * (2**NB) - 1);
    localparam logic [CW-1:0] C_ACQ_LAST = CW'(ACQ_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACQ   = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_addr;
    logic [CW-1:0]   r_acq_cnt;
    logic [PIXW-1:0] r_rr;
    logic            r_bank;
    logic            r_stop;

    logic [NB-1:0]    w_bins [N_REQ];
    logic [N_REQ-1:0] w_grant;
    logic [PIXW-1:0]  w_gnt_idx;
    logic             w_gnt_any;
    logic [PIXW:0]    w_sum;
    logic [PIXW-1:0]  w_cand;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bins
        assign w_bins[g] = bus.req_bin[g*NB +: NB];
    end

    // Search upward from the round-robin pointer, wrapping at N_REQ.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        if (r_state == S_ACQ) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_sum = {1'b0, r_rr} + (PIXW+1)'(k);
                if (w_sum >= (PIXW+1)'(N_REQ)) begin
                    w_sum = w_sum - (PIXW+1)'(N_REQ);
                end
                w_cand = w_sum[PIXW-1:0];
                if (!w_gnt_any && bus.req_valid[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
            if (w_gnt_any) begin
                w_grant[w_gnt_idx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign busy          = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_clr_addr  <= '0;
            r_acq_cnt   <= '0;
            r_rr        <= '0;
            r_bank      <= 1'b0;
            r_stop      <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.clr_en  <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_bank <= 1'b0;
            frame_done  <= 1'b0;
            done_bank   <= 1'b0;
            err_tick    <= 1'b0;
        end else begin
            bus.wr_en   <= w_gnt_any;
            bus.clr_en  <= 1'b0;
            bus.wr_bank <= r_bank;
            frame_done  <= 1'b0;

            if (w_gnt_any) begin
                bus.wr_addr <= {w_gnt_idx, w_bins[w_gnt_idx]};
                r_rr        <= (w_gnt_idx == PIXW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end

            if (stop && r_state != S_IDLE) begin
                r_stop <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    bus.clr_en  <= 1'b1;
                    bus.wr_addr <= r_clr_addr;
                    r_clr_addr  <= r_clr_addr + 1'b1;
                    if (acq_tick) begin
                        err_tick <= 1'b1;
                    end
                    if (r_clr_addr == C_CLR_LAST) begin
                        r_state   <= S_ACQ;
                        r_acq_cnt <= '0;
                    end
                end
                S_ACQ: begin
                    if (acq_tick) begin
                        if (r_acq_cnt == C_ACQ_LAST) begin
                            r_acq_cnt <= '0;
                            r_state   <= S_SWAP;
                        end else begin
                            r_acq_cnt <= r_acq_cnt + 1'b1;
                        end
                    end
                end
                S_SWAP: begin
                    r_bank     <= ~r_bank;
                    frame_done <= 1'b1;
                    done_bank  <= r_bank;
                    if (r_stop || stop) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b0;
                    end else begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
